// File: rtl/idli_fetch_ctl.sv
// idli_fetch_ctl: SQI flash instruction fetch sequencer.
// Issues a quad read (cmd 0x03, 24b byte address, 2 dummy cycles) at the
// current PC, then streams 4-nibble instructions to the decoder. Handles
// backend stall, execute redirect and PC wrap.
// Ports:
//   i_fch_gck          core clock
//   i_dcd_rst_n        async active-low reset
//   o_fch_sqi_cs_n     flash chip select (active-low)
//   o_fch_sqi_sck_en   flash clock enable
//   o_fch_sqi_oe       drive o_fch_sqi_data onto SQI pins
//   o_fch_sqi_data     command/address nibble
//   i_fch_sqi_data     read-data nibble from flash
//   o_fch_enc          instruction nibble to decoder
//   o_fch_enc_vld      o_fch_enc valid
//   i_fch_stall        backend cannot accept a nibble
//   i_fch_redirect     redirect request
//   i_fch_redirect_pc  redirect target word address
//   o_fch_pc           word address of instruction being streamed
module idli_fetch_ctl (
  input  logic        i_fch_gck,
  input  logic        i_dcd_rst_n,
  output logic        o_fch_sqi_cs_n,
  output logic        o_fch_sqi_sck_en,
  output logic        o_fch_sqi_oe,
  output logic [3:0]  o_fch_sqi_data,
  input  logic [3:0]  i_fch_sqi_data,
  output logic [3:0]  o_fch_enc,
  output logic        o_fch_enc_vld,
  input  logic        i_fch_stall,
  input  logic        i_fch_redirect,
  input  logic [15:0] i_fch_redirect_pc,
  output logic [15:0] o_fch_pc
);

  localparam int unsigned PC_W  = 16;
  localparam int unsigned PH_W  = 3;
  localparam int unsigned NIB_W = 2;
  localparam int unsigned AD_W  = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DUMMY   = 3'd3,
    ST_STREAM  = 3'd4,
    ST_RESTART = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [NIB_W-1:0]    nib_q,   nib_d;
  logic [PC_W-1:0]     pc_q,    pc_d;

  logic                cs_n_c, sck_en_c, oe_c, enc_vld_c;
  logic [3:0]          sqi_data_c, enc_c, addr_nib_c;
  logic [AD_W-1:0]     addr_c;

  // State and datapath registers
  always_ff @(posedge i_fch_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      nib_q   <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      nib_q   <= nib_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, phase/nibble counters and PC
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    nib_d   = nib_q;
    pc_d    = pc_q;
    if (i_fch_redirect) begin
      // Redirect overrides stall and any in-flight instruction
      state_d = ST_RESTART;
      pc_d    = i_fch_redirect_pc;
      phase_d = '0;
      nib_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESTART: begin
          state_d = ST_CMD;
          phase_d = '0;
          nib_d   = '0;
        end
        ST_CMD: begin
          if (!i_fch_stall) begin
            if (phase_q == PH_W'(1)) begin
              state_d = ST_ADDR;
              phase_d = '0;
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
        end
        ST_ADDR: begin
          if (!i_fch_stall) begin
            if (phase_q == PH_W'(5)) begin
              state_d = ST_DUMMY;
              phase_d = '0;
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
        end
        ST_DUMMY: begin
          if (!i_fch_stall) begin
            if (phase_q == PH_W'(1)) begin
              state_d = ST_STREAM;
              phase_d = '0;
              nib_d   = '0;
            end else begin
              phase_d = phase_q + PH_W'(1);
            end
          end
        end
        ST_STREAM: begin
          if (!i_fch_stall) begin
            nib_d = nib_q + NIB_W'(1);
            if (nib_q == NIB_W'(3)) begin
              // Wrap needs a fresh flash read from address 0
              if (pc_q == {PC_W{1'b1}}) begin
                pc_d    = '0;
                state_d = ST_RESTART;
              end else begin
                pc_d = pc_q + PC_W'(1);
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
          nib_d   = '0;
        end
      endcase
    end
  end

  // Byte address of the current word, MSB nibble selected by phase
  assign addr_c = {7'b0, pc_q, 1'b0};

  always_comb begin
    addr_nib_c = 4'h0;
    case (phase_q)
      3'd0:    addr_nib_c = addr_c[23:20];
      3'd1:    addr_nib_c = addr_c[19:16];
      3'd2:    addr_nib_c = addr_c[15:12];
      3'd3:    addr_nib_c = addr_c[11:8];
      3'd4:    addr_nib_c = addr_c[7:4];
      3'd5:    addr_nib_c = addr_c[3:0];
      default: addr_nib_c = 4'h0;
    endcase
  end

  // Output decode from state and stall
  always_comb begin
    cs_n_c     = 1'b1;
    sck_en_c   = 1'b0;
    oe_c       = 1'b0;
    sqi_data_c = 4'h0;
    enc_vld_c  = 1'b0;
    enc_c      = 4'h0;
    case (state_q)
      ST_CMD: begin
        cs_n_c     = 1'b0;
        sck_en_c   = !i_fch_stall;
        oe_c       = 1'b1;
        sqi_data_c = phase_q[0] ? 4'h3 : 4'h0;
      end
      ST_ADDR: begin
        cs_n_c     = 1'b0;
        sck_en_c   = !i_fch_stall;
        oe_c       = 1'b1;
        sqi_data_c = addr_nib_c;
      end
      ST_DUMMY: begin
        cs_n_c   = 1'b0;
        sck_en_c = !i_fch_stall;
      end
      ST_STREAM: begin
        cs_n_c    = 1'b0;
        sck_en_c  = !i_fch_stall;
        enc_vld_c = !i_fch_stall;
        enc_c     = i_fch_sqi_data;
      end
      default: begin
        cs_n_c = 1'b1;
      end
    endcase
  end

  assign o_fch_sqi_cs_n   = cs_n_c;
  assign o_fch_sqi_sck_en = sck_en_c;
  assign o_fch_sqi_oe     = oe_c;
  assign o_fch_sqi_data   = sqi_data_c;
  assign o_fch_enc        = enc_c;
  assign o_fch_enc_vld    = enc_vld_c;
  assign o_fch_pc         = pc_q;

endmodule

// File: tb/tb_idli_fetch_ctl.sv
// tb_idli_fetch_ctl: directed and random stimulus against a queue-based
// model of the fetch protocol.
module tb_idli_fetch_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n, sck_en, oe, vld;
  logic [3:0]  sqo, sqi, enc;
  logic        stall, redirect;
  logic [15:0] rpc, pc;

  always #5 clk = ~clk;

  idli_fetch_ctl dut (
    .i_fch_gck         (clk),
    .i_dcd_rst_n       (rst_n),
    .o_fch_sqi_cs_n    (cs_n),
    .o_fch_sqi_sck_en  (sck_en),
    .o_fch_sqi_oe      (oe),
    .o_fch_sqi_data    (sqo),
    .i_fch_sqi_data    (sqi),
    .o_fch_enc         (enc),
    .o_fch_enc_vld     (vld),
    .i_fch_stall       (stall),
    .i_fch_redirect    (redirect),
    .i_fch_redirect_pc (rpc),
    .o_fch_pc          (pc)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 preamble (cmd/addr/dummy queue), 2 stream, 3 restart
  int          m_mode = 0;
  int          m_q[$];
  logic [15:0] m_pc   = 16'h0;
  int          m_cnt  = 0;
  int          cyc    = 0;
  int          first_vld = -1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sequence of flash-bound cycles for a read at word p; -1 is a dummy cycle
  task automatic fill(input logic [15:0] p);
    logic [23:0] a;
    a = {7'b0, p, 1'b0};
    m_q.delete();
    m_q.push_back(0);
    m_q.push_back(3);
    for (int i = 0; i < 6; i++) m_q.push_back(int'(a[23-4*i -: 4]));
    m_q.push_back(-1);
    m_q.push_back(-1);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 16'h0;
    m_cnt  = 0;
    m_q.delete();
  endtask

  task automatic step(input logic rs, input logic st, input logic rd,
                      input logic [15:0] rp, input logic [3:0] fd);
    logic       e_cs, e_sck, e_oe, e_vld;
    logic [3:0] e_data, e_enc;
    int         head;
    @(negedge clk);
    rst_n = rs; stall = st; redirect = rd; rpc = rp; sqi = fd;
    #1;
    if (!rs) model_reset();
    e_cs = 1'b1; e_sck = 1'b0; e_oe = 1'b0; e_vld = 1'b0;
    e_data = 4'h0; e_enc = 4'h0;
    if (m_mode == 1) begin
      head   = m_q[0];
      e_cs   = 1'b0;
      e_sck  = !st;
      e_oe   = (head >= 0);
      e_data = (head >= 0) ? 4'(head) : 4'h0;
    end else if (m_mode == 2) begin
      e_cs  = 1'b0;
      e_sck = !st;
      e_vld = !st;
      e_enc = fd;
    end
    chk("cs_n",     16'(cs_n),   16'(e_cs));
    chk("sck_en",   16'(sck_en), 16'(e_sck));
    chk("oe",       16'(oe),     16'(e_oe));
    chk("sqi_data", 16'(sqo),    16'(e_data));
    chk("enc_vld",  16'(vld),    16'(e_vld));
    chk("enc",      16'(enc),    16'(e_enc));
    chk("pc",       pc,          m_pc);
    if (vld === 1'b1 && first_vld < 0) first_vld = cyc;
    @(posedge clk);
    cyc++;
    if (!rs) model_reset();
    else if (rd) begin
      m_pc = rp; m_mode = 3; m_cnt = 0;
    end else begin
      case (m_mode)
        0, 3: begin fill(m_pc); m_mode = 1; end
        1: if (!st) begin
             void'(m_q.pop_front());
             if (m_q.size() == 0) begin m_mode = 2; m_cnt = 0; end
           end
        2: if (!st) begin
             m_cnt++;
             if (m_cnt == 4) begin
               m_cnt = 0;
               if (m_pc == 16'hFFFF) begin m_pc = 16'h0; m_mode = 3; end
               else m_pc = m_pc + 16'd1;
             end
           end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 4'($urandom));
  endtask

  logic [3:0] nibs [8];
  logic [15:0] r_pc;
  logic        r_st, r_rd;

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; rpc = 16'h0; sqi = 4'h5;
    nibs = '{4'hA, 4'hB, 4'hC, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};

    // Reset values, including under stall and redirect
    step(1'b0, 1'b0, 1'b0, 16'h0, 4'h7);
    step(1'b0, 1'b1, 1'b1, 16'h4321, 4'h9);
    step(1'b0, 1'b0, 1'b0, 16'h0, 4'hF);

    // Release: preamble cycles 0..10, stream from cycle 11
    cyc = 0; first_vld = -1;
    run(11);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h0, nibs[i]);
      if (i == 3) begin #1; chk("pc_after_D", pc, 16'h0001); end
    end
    chk("first_vld_cycle", 16'(first_vld), 16'd11);
    #1; chk("pc_after_4", pc, 16'h0002);

    // Stall three cycles after the second nibble
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h6);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h7);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0, 4'hE);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h8);
    #1; chk("pc_hold_stall", pc, 16'h0002);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h9);
    #1; chk("pc_after_stall", pc, 16'h0003);

    // Redirect mid-instruction to 0x1234
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h2);
    step(1'b1, 1'b0, 1'b1, 16'h1234, 4'h3);
    #1; chk("redir_cs_n", 16'(cs_n), 16'd1);
    chk("redir_pc", pc, 16'h1234);
    run(15);

    // Redirect together with stall during ADDR
    step(1'b1, 1'b0, 1'b1, 16'h00AB, 4'h0);
    run(5);
    step(1'b1, 1'b1, 1'b1, 16'h0BCD, 4'h0);
    #1; chk("redir_stall_cs_n", 16'(cs_n), 16'd1);
    chk("redir_stall_pc", pc, 16'h0BCD);
    // Redirect during RESTART extends it by one cycle
    step(1'b1, 1'b0, 1'b1, 16'h0C00, 4'h0);
    #1; chk("restart_redir_pc", pc, 16'h0C00);
    run(14);

    // Wrap at 0xFFFF
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 4'h0);
    run(15);
    #1; chk("wrap_pc", pc, 16'h0000);
    chk("wrap_cs_n", 16'(cs_n), 16'd1);
    run(16);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r_st = ($urandom_range(0, 3) == 0);
      r_rd = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       r_pc = 16'hFFFF;
        1:       r_pc = 16'hFFFE;
        default: r_pc = 16'($urandom);
      endcase
      step(1'b1, r_st, r_rd, r_pc, 4'($urandom));
    end

    // Asynchronous reset mid-operation
    run(30);
    @(negedge clk);
    #2; sqi = 4'hB; rst_n = 1'b0;
    #1;
    chk("async_cs_n",   16'(cs_n),   16'd1);
    chk("async_sck_en", 16'(sck_en), 16'd0);
    chk("async_oe",     16'(oe),     16'd0);
    chk("async_data",   16'(sqo),    16'd0);
    chk("async_vld",    16'(vld),    16'd0);
    chk("async_enc",    16'(enc),    16'd0);
    chk("async_pc",     pc,          16'h0);
    model_reset();
    step(1'b0, 1'b0, 1'b0, 16'h0, 4'h3);
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
